// File: rtl/color_config_master_pkg.sv
// Shared definitions for the colour config-bus master: bus widths, register map,
// active-low handshake levels and the master FSM encoding.
package color_config_master_pkg;

  localparam int CFG_ADDR_W = 4;
  localparam int CFG_DATA_W = 14;

  localparam logic [CFG_ADDR_W-1:0] ADDR_VGA_CONFIG  = 4'h1;
  localparam logic [CFG_ADDR_W-1:0] ADDR_VGA_COLOR   = 4'h2;
  localparam logic [CFG_ADDR_W-1:0] ADDR_VGA_QUADRAN = 4'h3;

  // C_Valid / C_Rdy are both asserted low
  localparam logic BUS_ACTIVE = 1'b0;
  localparam logic BUS_IDLE   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_DRIVE   = 2'd2,
    ST_RELEASE = 2'd3
  } cfg_state_e;

endpackage

// File: rtl/color_config_master_fifo.sv
// Command queue: synchronous FIFO with RAM-style storage and a registered read port
// that presents the popped entry on the cycle after the pop.
module color_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Push,
  input  logic [WIDTH-1:0] Push_Data,
  input  logic             Pop,
  output logic [WIDTH-1:0] Pop_Data,
  output logic             Full,
  output logic             Empty,
  output logic [CNT_W-1:0] Count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign Full     = (count_q == CNT_W'(DEPTH));
  assign Empty    = (count_q == '0);
  assign Count    = count_q;
  assign Pop_Data = rd_data_q;
  assign do_push  = Push && !Full;
  assign do_pop   = Pop && !Empty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage and read register carry no reset so they map onto block RAM
  always_ff @(posedge Clk) begin
    if (do_push) mem_q[wr_ptr_q] <= Push_Data;
    if (do_pop)  rd_data_q <= mem_q[rd_ptr_q];
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/color_config_master.sv
// Config-bus master: queues upstream colour commands and issues each one over an
// active-low valid/acknowledge handshake with a bounded wait for the acknowledge.
module color_config_master
  import color_config_master_pkg::*;
#(
  parameter int C_ADDR_WIDTH   = CFG_ADDR_W,
  parameter int C_DATA_WIDTH   = CFG_DATA_W,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Cmd_Valid,
  input  logic [C_ADDR_WIDTH-1:0] Cmd_Addr,
  input  logic [C_DATA_WIDTH-1:0] Cmd_Data,
  output logic                    Cmd_Rdy,
  output logic [C_ADDR_WIDTH-1:0] C_Addr,
  output logic [C_DATA_WIDTH-1:0] C_Data,
  output logic                    C_Valid,
  input  logic                    C_Rdy,
  output logic                    Done,
  output logic                    Err,
  output logic [C_ADDR_WIDTH-1:0] Err_Addr,
  output logic                    Busy
);

  localparam int ENT_W = C_ADDR_WIDTH + C_DATA_WIDTH;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  cfg_state_e              state_q, state_d;
  logic [TO_W-1:0]         timeout_q, timeout_d;
  logic [C_ADDR_WIDTH-1:0] c_addr_q, c_addr_d, err_addr_q, err_addr_d;
  logic [C_DATA_WIDTH-1:0] c_data_q, c_data_d;
  logic                    c_valid_q, c_valid_d;
  logic                    done_q, done_d, err_q, err_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENT_W-1:0] fifo_rd_data;
  logic [CNT_W-1:0] fifo_count;

  assign Cmd_Rdy   = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign fifo_push = Cmd_Valid && !fifo_full;
  assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
  assign Busy      = (state_q != ST_IDLE) || !fifo_empty;

  color_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .Clk       (Clk),
    .Rst       (Rst),
    .Push      (fifo_push),
    .Push_Data ({Cmd_Addr, Cmd_Data}),
    .Pop       (fifo_pop),
    .Pop_Data  (fifo_rd_data),
    .Full      (fifo_full),
    .Empty     (fifo_empty),
    .Count     (fifo_count)
  );

  // LOAD exists because the queue's read register delivers the head one cycle after the pop
  always_comb begin
    state_d    = state_q;
    timeout_d  = timeout_q;
    c_addr_d   = c_addr_q;
    c_data_d   = c_data_q;
    c_valid_d  = c_valid_q;
    err_addr_d = err_addr_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fifo_pop) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        {c_addr_d, c_data_d} = fifo_rd_data;
        c_valid_d = BUS_ACTIVE;
        timeout_d = '0;
        state_d   = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (C_Rdy == BUS_ACTIVE) begin
          c_valid_d = BUS_IDLE;
          done_d    = 1'b1;
          state_d   = ST_RELEASE;
        end else if (timeout_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          c_valid_d  = BUS_IDLE;
          err_d      = 1'b1;
          err_addr_d = c_addr_q;
          state_d    = ST_RELEASE;
        end else begin
          timeout_d = timeout_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (C_Rdy == BUS_IDLE) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      timeout_q  <= '0;
      c_addr_q   <= '0;
      c_data_q   <= '0;
      c_valid_q  <= BUS_IDLE;
      err_addr_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timeout_q  <= timeout_d;
      c_addr_q   <= c_addr_d;
      c_data_q   <= c_data_d;
      c_valid_q  <= c_valid_d;
      err_addr_q <= err_addr_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign C_Addr   = c_addr_q;
  assign C_Data   = c_data_q;
  assign C_Valid  = c_valid_q;
  assign Done     = done_q;
  assign Err      = err_q;
  assign Err_Addr = err_addr_q;

endmodule

// File: tb/tb_color_config_master.sv
// Scoreboard bench for color_config_master: a default instance exercised through a
// programmable responder, plus a short-timeout instance for the no-acknowledge path.
module tb_color_config_master;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Cmd_Valid = 1'b0;
  logic [3:0]  Cmd_Addr = '0;
  logic [13:0] Cmd_Data = '0;
  logic        Cmd_Rdy, C_Valid, Done, Err, Busy;
  logic [3:0]  C_Addr, Err_Addr;
  logic [13:0] C_Data;
  logic        C_Rdy = 1'b1;

  logic        t_valid = 1'b0;
  logic [3:0]  t_addr = '0;
  logic [13:0] t_data = '0;
  logic        t_cmd_rdy, t_cv, t_done, t_err, t_busy;
  logic [3:0]  t_caddr, t_erraddr;
  logic [13:0] t_cdata;
  logic        t_crdy = 1'b1;

  always #5 Clk = ~Clk;

  color_config_master dut (
    .Clk(Clk), .Rst(Rst), .Cmd_Valid(Cmd_Valid), .Cmd_Addr(Cmd_Addr), .Cmd_Data(Cmd_Data),
    .Cmd_Rdy(Cmd_Rdy), .C_Addr(C_Addr), .C_Data(C_Data), .C_Valid(C_Valid), .C_Rdy(C_Rdy),
    .Done(Done), .Err(Err), .Err_Addr(Err_Addr), .Busy(Busy)
  );

  color_config_master #(.TIMEOUT_CYCLES(8)) dut_to (
    .Clk(Clk), .Rst(Rst), .Cmd_Valid(t_valid), .Cmd_Addr(t_addr), .Cmd_Data(t_data),
    .Cmd_Rdy(t_cmd_rdy), .C_Addr(t_caddr), .C_Data(t_cdata), .C_Valid(t_cv), .C_Rdy(t_crdy),
    .Done(t_done), .Err(t_err), .Err_Addr(t_erraddr), .Busy(t_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: {addr, data} of every accepted command, in push order
  logic [17:0] exp_q[$];
  logic [17:0] exp_ent;
  logic [3:0]  cur_addr = '0;
  logic [13:0] cur_data = '0;
  int issued = 0, done_cnt = 0, err_cnt = 0;
  int low_len = 0, last_low = 0, high_len = 0, last_gap = 0;
  logic prev_v = 1'b1;

  always @(posedge Clk) begin
    #1;
    if (Rst) begin
      prev_v = 1'b1;
    end else begin
      if (prev_v && !C_Valid) begin
        issued++;
        last_gap = high_len;
        low_len  = 1;
        chk("sb_nonempty", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_ent  = exp_q.pop_front();
          cur_addr = exp_ent[17:14];
          cur_data = exp_ent[13:0];
          chk("issue_addr", C_Addr, cur_addr);
          chk("issue_data", C_Data, cur_data);
        end
      end else if (!C_Valid) begin
        low_len++;
        chk("hold_addr", C_Addr, cur_addr);
        chk("hold_data", C_Data, cur_data);
      end else if (!prev_v) begin
        last_low = low_len;
        high_len = 1;
      end else begin
        high_len++;
      end
      if (Done) done_cnt++;
      if (Err)  err_cnt++;
      prev_v = C_Valid;
    end
  end

  // Responder: acknowledges ack_after edges after C_Valid falls, holds C_Rdy low hold_cycles
  int ack_after = 3, hold_cycles = 1, lowcnt = 0, holdcnt = 0;
  bit stall = 1'b0;

  always @(posedge Clk) begin
    #2;
    if (Rst) begin
      C_Rdy = 1'b1; lowcnt = 0; holdcnt = 0;
    end else if (!C_Valid) begin
      lowcnt++;
      if (!stall && lowcnt > ack_after) C_Rdy = 1'b0;
    end else begin
      lowcnt = 0;
      if (!C_Rdy) begin
        holdcnt++;
        if (holdcnt >= hold_cycles) begin
          C_Rdy = 1'b1; holdcnt = 0;
        end
      end
    end
  end

  task automatic push_cmd(input logic [3:0] a, input logic [13:0] d, output bit acc);
    @(negedge Clk);
    Cmd_Valid = 1'b1; Cmd_Addr = a; Cmd_Data = d;
    acc = Cmd_Rdy;
    if (acc) exp_q.push_back({a, d});
    @(posedge Clk); #1;
    Cmd_Valid = 1'b0;
    $display("push addr=%0h data=%0h accepted=%0d", a, d, acc);
  endtask

  task automatic wait_idle(input int maxc, input string tag);
    for (int n = 0; n < maxc; n++) begin
      @(posedge Clk); #3;
      if (!Busy) break;
    end
    chk(tag, Busy, 0);
  endtask

  initial begin
    bit acc[6];
    bit got;
    int bi, bd, be, low;

    // Reset applied with no clock edge yet
    #1 Rst = 1'b1; #2;
    chk("rst_cvalid", C_Valid, 1);   chk("rst_caddr", C_Addr, 0);
    chk("rst_cdata", C_Data, 0);     chk("rst_done", Done, 0);
    chk("rst_err", Err, 0);          chk("rst_erraddr", Err_Addr, 0);
    chk("rst_busy", Busy, 0);        chk("rst_cmdrdy", Cmd_Rdy, 1);
    repeat (2) @(posedge Clk);
    @(negedge Clk) Rst = 1'b0;

    // Single write with acknowledge three edges after C_Valid falls
    ack_after = 3; hold_cycles = 1; bi = issued; bd = done_cnt; be = err_cnt;
    push_cmd(4'h2, 14'h2ABC, acc[0]);
    chk("sw_accept", acc[0], 1);
    chk("lat_n0", C_Valid, 1);
    @(posedge Clk); #1 chk("lat_n1", C_Valid, 1);
    @(posedge Clk); #1 chk("lat_n2", C_Valid, 0);
    wait_idle(40, "sw_idle");
    chk("sw_low_len", last_low, 4);
    chk("sw_done", done_cnt - bd, 1);
    chk("sw_err", err_cnt - be, 0);
    chk("sw_issued", issued - bi, 1);
    chk("sw_crdy_high", C_Rdy, 1);
    $display("single write: low=%0d done=%0d", last_low, done_cnt - bd);

    // Long acknowledge: C_Rdy held low three cycles, next command must wait for release
    ack_after = 0; hold_cycles = 3; bi = issued; bd = done_cnt;
    push_cmd(4'h1, 14'h0111, acc[0]);
    push_cmd(4'h5, 14'h1555, acc[1]);
    wait_idle(60, "la_idle");
    chk("la_done", done_cnt - bd, 2);
    chk("la_gap", last_gap, 5);
    chk("la_low", last_low, 1);
    chk("la_issued", issued - bi, 2);
    $display("long ack: gap=%0d done=%0d", last_gap, done_cnt - bd);

    // Backpressure: stalled responder, six back-to-back pushes
    stall = 1'b1; hold_cycles = 1; bi = issued; be = err_cnt;
    for (int i = 0; i < 6; i++) push_cmd(4'(i + 6), 14'(14'h0100 + i), acc[i]);
    for (int i = 0; i < 5; i++) chk("bp_accept", acc[i], 1);
    chk("bp_drop", acc[5], 0);
    repeat (3) @(posedge Clk);
    #1;
    chk("bp_driving", C_Valid, 0);
    chk("bp_full", Cmd_Rdy, 0);
    chk("bp_in_flight", issued - bi, 1);
    stall = 1'b0;
    wait_idle(100, "bp_idle");
    chk("bp_issued", issued - bi, 5);
    chk("bp_err", err_cnt - be, 0);
    chk("bp_sb_empty", exp_q.size(), 0);
    $display("backpressure: issued=%0d", issued - bi);

    // Simultaneous push and pop with two entries queued
    bi = issued;
    push_cmd(4'hA, 14'h0AAA, acc[0]);
    push_cmd(4'hB, 14'h0BBB, acc[1]);
    push_cmd(4'hC, 14'h0CCC, acc[2]);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge Clk); #3;
      got = Done;
    end
    chk("sp_done_seen", got, 1);
    @(posedge Clk);
    push_cmd(4'hD, 14'h0DDD, acc[3]);
    push_cmd(4'hE, 14'h0EEE, acc[4]);
    push_cmd(4'hF, 14'h0FFF, acc[5]);
    for (int i = 0; i < 6; i++) chk("sp_accept", acc[i], 1);
    chk("sp_full", Cmd_Rdy, 0);
    wait_idle(80, "sp_idle");
    chk("sp_issued", issued - bi, 6);
    chk("sp_gap", last_gap, 3);
    chk("sp_sb_empty", exp_q.size(), 0);
    $display("simultaneous push/pop: issued=%0d", issued - bi);

    // Reset while driving with two commands queued
    stall = 1'b1;
    push_cmd(4'h7, 14'h0777, acc[0]);
    push_cmd(4'h8, 14'h0888, acc[1]);
    push_cmd(4'h9, 14'h0999, acc[2]);
    chk("rm_driving", C_Valid, 0);
    @(negedge Clk); #2 Rst = 1'b1; #1;
    chk("rm_cvalid", C_Valid, 1);    chk("rm_cmdrdy", Cmd_Rdy, 1);
    chk("rm_busy", Busy, 0);         chk("rm_done", Done, 0);
    chk("rm_err", Err, 0);           chk("rm_erraddr", Err_Addr, 0);
    exp_q.delete();
    repeat (2) @(negedge Clk);
    Rst = 1'b0; stall = 1'b0;
    bi = issued; bd = done_cnt; be = err_cnt;
    repeat (20) @(posedge Clk);
    #1;
    chk("rm_no_issue", issued - bi, 0);
    chk("rm_no_done", done_cnt - bd, 0);
    chk("rm_no_err", err_cnt - be, 0);
    chk("rm_idle_valid", C_Valid, 1);
    chk("rm_idle_busy", Busy, 0);
    $display("reset mid-drive: issued after reset=%0d", issued - bi);

    // Timeout on the short-timeout instance, responder never acknowledges
    t_crdy = 1'b1;
    @(negedge Clk);
    chk("to_cmdrdy", t_cmd_rdy, 1);
    t_valid = 1'b1; t_addr = 4'h3; t_data = 14'h0333;
    @(negedge Clk);
    t_addr = 4'h5; t_data = 14'h0555;
    @(posedge Clk); #1 t_valid = 1'b0;
    low = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      if (t_err) break;
      if (!t_cv) low++;
    end
    chk("to_low", low, 8);
    chk("to_err", t_err, 1);
    chk("to_err_addr", t_erraddr, 4'h3);
    chk("to_done", t_done, 0);
    @(posedge Clk); #1 chk("to_err_pulse", t_err, 0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge Clk); #1;
      got = !t_cv;
    end
    chk("to_next_issued", got, 1);
    chk("to_next_addr", t_caddr, 4'h5);
    chk("to_next_data", t_cdata, 14'h0555);
    chk("to_erraddr_held", t_erraddr, 4'h3);
    @(negedge Clk) t_crdy = 1'b0;
    @(posedge Clk); #1;
    chk("to_ack_done", t_done, 1);
    chk("to_ack_release", t_cv, 1);
    @(negedge Clk) t_crdy = 1'b1;
    repeat (3) @(posedge Clk);
    #1 chk("to_idle_busy", t_busy, 0);
    $display("timeout: low=%0d err_addr=%0h", low, t_erraddr);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
